// File: rtl/spmv_xvec_streamer.sv
// spmv_xvec_streamer: streams an X vector from HBM over AXI4 reads into an AXI-Stream,
// splitting bursts at 4 KB boundaries and issuing reads only when the buffer has room for them.
module spmv_xvec_streamer #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic         pcie_aclk,
  input  logic         pcie_areset,
  input  logic         start,
  input  logic [47:0]  base_addr,
  input  logic [31:0]  num_beats,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [47:0]  m_axi_hbm_araddr,
  output logic [3:0]   m_axi_hbm_arlen,
  output logic [2:0]   m_axi_hbm_arsize,
  output logic [1:0]   m_axi_hbm_arburst,
  output logic         m_axi_hbm_arvalid,
  input  logic         m_axi_hbm_arready,
  input  logic [255:0] m_axi_hbm_rdata,
  input  logic [1:0]   m_axi_hbm_rresp,
  input  logic         m_axi_hbm_rlast,
  input  logic         m_axi_hbm_rvalid,
  output logic         m_axi_hbm_rready,
  output logic [255:0] m_axis_xvec_tdata,
  output logic         m_axis_xvec_tvalid,
  output logic         m_axis_xvec_tlast,
  input  logic         m_axis_xvec_tready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [47:0] r_addr;
  logic [31:0] r_rem, r_out, r_total, r_sent, r_cnt;
  logic r_arvalid, r_err, r_tvalid;
  logic [255:0] r_tdata;
  logic [255:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_mcnt;
  logic [31:0] w_b4k, w_l16, w_len;
  logic w_credit, w_hs, w_racc, w_pop, w_load, w_rd, w_byp, w_wr, w_last, w_unused;
  assign w_b4k    = 32'd128 - {25'd0, r_addr[11:5]};
  assign w_l16    = r_rem < 32'd16 ? r_rem : 32'd16;
  assign w_len    = w_l16 < w_b4k ? w_l16 : w_b4k;
  assign w_credit = ({1'b0, r_cnt} + {1'b0, r_out} + {1'b0, w_len}) <= 33'(FIFO_DEPTH);
  assign w_hs     = r_arvalid & m_axi_hbm_arready;
  // beats arriving with nothing outstanding belong to an abandoned job and are dropped
  assign w_racc   = m_axi_hbm_rvalid & (r_out != 32'd0);
  assign w_pop    = r_tvalid & m_axis_xvec_tready;
  assign w_load   = !r_tvalid | m_axis_xvec_tready;
  assign w_rd     = w_load & (r_mcnt != '0);
  assign w_byp    = w_load & (r_mcnt == '0) & w_racc;
  assign w_wr     = w_racc & !w_byp;
  assign w_last   = r_sent == r_total - 32'd1;
  assign w_unused = m_axi_hbm_rlast;
  assign m_axi_hbm_araddr   = r_addr;
  assign m_axi_hbm_arlen    = 4'(w_len - 32'd1);
  assign m_axi_hbm_arsize   = 3'b101;
  assign m_axi_hbm_arburst  = 2'b01;
  assign m_axi_hbm_arvalid  = r_arvalid;
  assign m_axi_hbm_rready   = 1'b1;
  assign m_axis_xvec_tdata  = r_tdata;
  assign m_axis_xvec_tvalid = r_tvalid;
  assign m_axis_xvec_tlast  = r_tvalid & w_last;
  assign busy = (r_state == ISSUE) | (r_state == DRAIN);
  assign done = r_state == DONE;
  assign err  = r_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (num_beats == 32'd0 ? DONE : ISSUE) : IDLE;
      ISSUE:   w_next = (w_hs && r_rem == w_len) ? DRAIN : ISSUE;
      DRAIN:   w_next = (w_pop && w_last) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge pcie_aclk) if (w_wr) r_mem[r_wp] <= m_axi_hbm_rdata;
  always_ff @(posedge pcie_aclk) begin
    if (pcie_areset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_out     <= '0;
      r_total   <= '0;
      r_sent    <= '0;
      r_cnt     <= '0;
      r_arvalid <= 1'b0;
      r_err     <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_mcnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_addr  <= base_addr;
        r_rem   <= num_beats;
        r_total <= num_beats;
        r_sent  <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_hs) begin
          r_addr <= r_addr + {11'd0, w_len, 5'd0};
          r_rem  <= r_rem - w_len;
        end
        if (w_pop) r_sent <= r_sent + 32'd1;
        if (w_racc && m_axi_hbm_rresp != 2'b00) r_err <= 1'b1;
      end
      r_arvalid <= w_hs ? 1'b0 : r_arvalid | (r_state == ISSUE && r_rem != 32'd0 && w_credit);
      r_out  <= r_out + (w_hs ? w_len : 32'd0) - 32'(w_racc);
      r_cnt  <= r_cnt + 32'(w_racc) - 32'(w_pop);
      r_mcnt <= r_mcnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      if (w_load) begin
        r_tvalid <= w_rd | w_byp;
        r_tdata  <= w_rd ? r_mem[r_rp] : m_axi_hbm_rdata;
      end
    end
  end
endmodule

// File: tb/tb_spmv_xvec_streamer.sv
// tb_spmv_xvec_streamer: directed scenarios against an AXI read-slave model and a stream sink.
module tb_spmv_xvec_streamer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start = 0, busy, done, err;
  logic [47:0] base_addr = 0;
  logic [31:0] num_beats = 0;
  logic [47:0] araddr; logic [3:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic arvalid, arready = 0;
  logic [255:0] rdata = 0; logic [1:0] rresp = 0; logic rlast = 0, rvalid = 0, rready;
  logic [255:0] tdata; logic tvalid, tlast, tready = 0;

  spmv_xvec_streamer #(.FIFO_DEPTH(64)) dut (
    .pcie_aclk(clk), .pcie_areset(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err(err),
    .m_axi_hbm_araddr(araddr), .m_axi_hbm_arlen(arlen), .m_axi_hbm_arsize(arsize),
    .m_axi_hbm_arburst(arburst), .m_axi_hbm_arvalid(arvalid), .m_axi_hbm_arready(arready),
    .m_axi_hbm_rdata(rdata), .m_axi_hbm_rresp(rresp), .m_axi_hbm_rlast(rlast),
    .m_axi_hbm_rvalid(rvalid), .m_axi_hbm_rready(rready),
    .m_axis_xvec_tdata(tdata), .m_axis_xvec_tvalid(tvalid), .m_axis_xvec_tlast(tlast),
    .m_axis_xvec_tready(tready));

  int tests = 0, fails = 0;
  logic [47:0] rq_addr[$]; logic rq_last[$];
  logic [47:0] ar_addr[$]; logic [3:0] ar_len[$];
  logic [255:0] out_data[$]; logic out_last[$];
  int cyc = 0, ar_beats = 0, out_beats = 0, r_beats = 0, max_fly = 0, done_cnt = 0, tv_seen = 0;
  int hold_viol = 0, err_viol = 0, err_idx = -1, err_cyc = -1, first_r_cyc = -1, first_o_cyc = -1, last_o_cyc = -1;
  bit r_en = 1;
  logic prev_stall = 0; logic [255:0] prev_data = 0;

  function automatic logic [255:0] pat(input logic [47:0] a);
    return {8{a[31:0] ^ 32'h5EED0000}};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (arvalid && arready) begin
      ar_addr.push_back(araddr); ar_len.push_back(arlen);
      for (int i = 0; i <= int'(arlen); i++) begin
        rq_addr.push_back(araddr + 48'(32 * i)); rq_last.push_back(i == int'(arlen));
      end
      ar_beats += int'(arlen) + 1;
    end
    if (rvalid && rready) begin
      if (first_r_cyc < 0) first_r_cyc = cyc;
      if (r_beats == err_idx) err_cyc = cyc;
      r_beats++;
      void'(rq_addr.pop_front()); void'(rq_last.pop_front());
    end
    if (tvalid && tready) begin
      out_data.push_back(tdata); out_last.push_back(tlast);
      if (first_o_cyc < 0) first_o_cyc = cyc;
      last_o_cyc = cyc; out_beats++;
    end
    if (prev_stall && (!tvalid || tdata !== prev_data)) hold_viol++;
    prev_stall = tvalid && !tready; prev_data = tdata;
    if (done) done_cnt++;
    if (tvalid) tv_seen++;
    if (ar_beats - out_beats > max_fly) max_fly = ar_beats - out_beats;
    #1;
    arready = 1;
    rvalid = r_en && rq_addr.size() > 0;
    if (rvalid) begin rdata = pat(rq_addr[0]); rlast = rq_last[0]; end
    else begin rdata = 0; rlast = 0; end
    rresp = (rvalid && r_beats == err_idx) ? 2'b10 : 2'b00;
  end

  always @(negedge clk)
    if (err_idx >= 0 && busy && ((err_cyc < 0 && err) || (err_cyc >= 0 && !err))) err_viol++;

  task automatic clear_logs();
    ar_addr.delete(); ar_len.delete(); out_data.delete(); out_last.delete();
    ar_beats = 0; out_beats = 0; r_beats = 0; max_fly = 0; done_cnt = 0; tv_seen = 0;
    hold_viol = 0; err_viol = 0; err_cyc = -1; first_r_cyc = -1; first_o_cyc = -1; last_o_cyc = -1;
  endtask

  task automatic start_job(input logic [47:0] b, input logic [31:0] n);
    @(posedge clk); #1 start = 1; base_addr = b; num_beats = n;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({arvalid, tvalid, tlast, busy, done, err} !== 6'b0)
      begin fails++; $display("FAIL reset_outputs got %b want 000000", {arvalid, tvalid, tlast, busy, done, err}); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_basic();
    bit ok; int bad = 0;
    clear_logs(); tready = 1;
    start_job(48'h1000, 40);
    wait_done(500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout got 0 want 1"); end
    @(negedge clk);
    tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL basic_done_pulse got %b want 00", {done, busy}); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    tests++;
    if (ar_addr.size() !== 3 || {ar_addr[0], ar_len[0], ar_addr[1], ar_len[1], ar_addr[2], ar_len[2]} !==
        {48'h1000, 4'd15, 48'h1200, 4'd15, 48'h1400, 4'd7})
      begin fails++; $display("FAIL basic_ar got %0d bursts first %h/%0d want 3 bursts 1000/15 1200/15 1400/7", ar_addr.size(), ar_addr[0], ar_len[0]); end
    for (int i = 0; i < out_data.size(); i++)
      if (out_data[i] !== pat(48'h1000 + 48'(32 * i)) || out_last[i] !== (i == 39)) bad++;
    tests++;
    if (out_beats !== 40 || bad !== 0) begin fails++; $display("FAIL basic_data got %0d beats %0d bad want 40 beats 0 bad", out_beats, bad); end
    tests++;
    if (last_o_cyc - first_o_cyc !== 39) begin fails++; $display("FAIL basic_throughput got span %0d want 39", last_o_cyc - first_o_cyc); end
    tests++;
    if (first_o_cyc - first_r_cyc !== 1) begin fails++; $display("FAIL basic_latency got %0d want 1", first_o_cyc - first_r_cyc); end
  endtask

  task automatic test_4k_split();
    bit ok; int bad = 0;
    clear_logs(); tready = 1;
    start_job(48'h0FC0, 4);
    wait_done(200, ok);
    tests++;
    if (!ok || ar_addr.size() !== 2 || {ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]} !== {48'h0FC0, 4'd1, 48'h1000, 4'd1})
      begin fails++; $display("FAIL split_ar got done %0b %0d bursts %h/%0d %h/%0d want 0fc0/1 1000/1", ok, ar_addr.size(), ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]); end
    for (int i = 0; i < out_data.size(); i++)
      if (out_data[i] !== pat(48'h0FC0 + 48'(32 * i)) || out_last[i] !== (i == 3)) bad++;
    tests++;
    if (out_beats !== 4 || bad !== 0) begin fails++; $display("FAIL split_data got %0d beats %0d bad want 4 beats 0 bad", out_beats, bad); end
  endtask

  task automatic test_backpressure();
    bit ok; int bad = 0;
    clear_logs(); tready = 0;
    start_job(48'h20000, 200);
    repeat (300) @(negedge clk);
    tests++;
    if (ar_beats !== 64 || arvalid !== 1'b0 || tvalid !== 1'b1 || busy !== 1'b1)
      begin fails++; $display("FAIL bp_stall got %0d beats arvalid %b tvalid %b busy %b want 64 0 1 1", ar_beats, arvalid, tvalid, busy); end
    tready = 1;
    wait_done(1000, ok);
    for (int i = 0; i < out_data.size(); i++)
      if (out_data[i] !== pat(48'h20000 + 48'(32 * i)) || out_last[i] !== (i == 199)) bad++;
    tests++;
    if (!ok || out_beats !== 200 || bad !== 0)
      begin fails++; $display("FAIL bp_data got done %0b %0d beats %0d bad want 1 200 0", ok, out_beats, bad); end
    tests++;
    if (max_fly > 64 || hold_viol !== 0)
      begin fails++; $display("FAIL bp_credit got inflight %0d holdviol %0d want <=64 0", max_fly, hold_viol); end
  endtask

  task automatic test_err();
    bit ok; int bad = 0;
    clear_logs(); tready = 1; err_idx = 4;
    start_job(48'h30000, 10);
    wait_done(300, ok);
    @(negedge clk);
    for (int i = 0; i < out_data.size(); i++)
      if (out_data[i] !== pat(48'h30000 + 48'(32 * i))) bad++;
    tests++;
    if (!ok || out_beats !== 10 || bad !== 0) begin fails++; $display("FAIL err_data got done %0b %0d beats %0d bad want 1 10 0", ok, out_beats, bad); end
    tests++;
    if (err !== 1'b1 || err_viol !== 0 || err_cyc < 0)
      begin fails++; $display("FAIL err_flag got err %b viol %0d errcyc %0d want 1 0 >=0", err, err_viol, err_cyc); end
    err_idx = -1;
    start_job(48'h31000, 2);
    @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
    wait_done(200, ok);
    tests++; if (!ok || err !== 1'b0) begin fails++; $display("FAIL err_clean_job got done %0b err %b want 1 0", ok, err); end
  endtask

  task automatic test_zero();
    clear_logs(); tready = 1;
    start_job(48'h0, 0);
    @(negedge clk);
    tests++; if ({done, busy} !== 2'b10) begin fails++; $display("FAIL zero_done got %b want 10", {done, busy}); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_len got %b want 0", done); end
    repeat (5) @(negedge clk);
    tests++;
    if (ar_addr.size() !== 0 || tv_seen !== 0)
      begin fails++; $display("FAIL zero_traffic got %0d ar %0d tvalid want 0 0", ar_addr.size(), tv_seen); end
  endtask

  task automatic test_reset_midjob();
    bit ok = 0; int bad = 0;
    clear_logs(); tready = 0; r_en = 0;
    start_job(48'h40000, 64);
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = ar_addr.size() >= 2; end
    tests++; if (!ok) begin fails++; $display("FAIL rst_mid_ar got %0d bursts want >=2", ar_addr.size()); end
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({arvalid, tvalid, tlast, busy, done, err} !== 6'b0)
      begin fails++; $display("FAIL rst_mid_outputs got %b want 000000", {arvalid, tvalid, tlast, busy, done, err}); end
    @(posedge clk); #1 rst = 0; r_en = 1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = rq_addr.size() == 0; end
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_discard got drained %0b tvalid %b busy %b want 1 0 0", ok, tvalid, busy); end
    clear_logs(); tready = 1;
    start_job(48'h50000, 3);
    wait_done(200, ok);
    for (int i = 0; i < out_data.size(); i++)
      if (out_data[i] !== pat(48'h50000 + 48'(32 * i)) || out_last[i] !== (i == 2)) bad++;
    tests++;
    if (!ok || out_beats !== 3 || bad !== 0 || ar_addr.size() !== 1)
      begin fails++; $display("FAIL rst_mid_newjob got done %0b %0d beats %0d bad %0d ar want 1 3 0 1", ok, out_beats, bad, ar_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4k_split();
    test_backpressure();
    test_err();
    test_zero();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
